snake_body_engine: RTL and testbench

- Game-logic stage directly upstream of VGA_Controller.
- Owns the snake: body FIFO of cell indices plus an occupancy bitmap.
- Advances the snake one cell per game tick and handles grow, wall and self-collision.
- Answers per-pixel "is this cell snake?" queries from the VGA pixel pipeline with fixed 1-cycle latency.
- Grid is 10x10-pixel cells over the 640x480 active area.

---
 rtl/snake_body_engine.sv | 215 +++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// rtl/snake_body_engine.sv - snake body FIFO, occupancy bitmap and move FSM; SNAKE_WRAP_EN wraps at walls
module snake_body_engine #(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 4,
    parameter int START_X  = 32,
    parameter int START_Y  = 24
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iTick,
    input  logic [1:0] iDir,
    input  logic       iGrow,
    input  logic       iRestart,
    input  logic [5:0] iQuery_X,
    input  logic [5:0] iQuery_Y,
    output logic       oHit,
    output logic [5:0] oHead_X,
    output logic [5:0] oHead_Y,
    output logic [6:0] oLength,
    output logic       oBusy,
    output logic       oDead,
    output logic       oMove_Done
);
    localparam int GRID_N = GRID_W * GRID_H;
    localparam int PW     = $clog2(MAX_LEN);
    localparam logic [PW:0] MAX_CNT   = (PW+1)'(MAX_LEN);
    localparam logic [11:0] INIT_BASE = 12'(START_Y * GRID_W + START_X - INIT_LEN + 1);

    typedef enum logic [2:0] {
        S_CLEAR, S_INIT, S_IDLE, S_CALC, S_CHECK, S_UPDATE, S_TRIM, S_DEAD
    } state_t;

    state_t state, state_nxt;

    logic          bitmap [0:GRID_N-1];
    logic [11:0]   fifo   [0:MAX_LEN-1];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [11:0]   clr_cnt, tail_idx, new_idx;
    logic [6:0]    init_k;
    logic [5:0]    new_x, new_y;
    logic [1:0]    dir;
    logic          grow_flag, keep_tail, rd_bit;

    logic [7:0]  nx, ny;
    logic [5:0]  calc_x, calc_y;
    logic [11:0] calc_idx, q_idx, init_idx;
    logic        calc_wall, take_grow, q_in;
    logic        bm_we, bm_wd;
    logic [11:0] bm_addr;

    // Candidate head one step along dir, with one spare bit so x/y = -1 and GRID_W/H are distinguishable
    always_comb begin
        nx = {2'b00, oHead_X};
        ny = {2'b00, oHead_Y};
        case (dir)
            2'b01:   nx = nx + 8'd1;
            2'b10:   nx = nx - 8'd1;
            2'b11:   ny = ny - 8'd1;
            default: ny = ny + 8'd1;
        endcase
        calc_x    = nx[5:0];
        calc_y    = ny[5:0];
        calc_wall = 1'b0;
`ifdef SNAKE_WRAP_EN
        if (nx[7])                       calc_x = 6'(GRID_W - 1);
        else if (nx[6:0] >= 7'(GRID_W))  calc_x = 6'd0;
        if (ny[7])                       calc_y = 6'(GRID_H - 1);
        else if (ny[6:0] >= 7'(GRID_H))  calc_y = 6'd0;
`else
        calc_wall = nx[7] | (nx[6:0] >= 7'(GRID_W)) | ny[7] | (ny[6:0] >= 7'(GRID_H));
`endif
        calc_idx = 12'(calc_y) * 12'(GRID_W) + 12'(calc_x);
    end

    assign take_grow = grow_flag && (count < MAX_CNT);
    assign init_idx  = INIT_BASE + 12'(init_k);
    assign q_in      = ({1'b0, iQuery_X} < 7'(GRID_W)) && ({1'b0, iQuery_Y} < 7'(GRID_H));
    assign q_idx     = 12'(iQuery_Y) * 12'(GRID_W) + 12'(iQuery_X);
    assign oBusy     = (state != S_IDLE);
    assign oDead     = (state == S_DEAD);

    always_ff @(posedge iCLK) begin
        if (iRST) state <= S_CLEAR;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bm_we     = 1'b0;
        bm_wd     = 1'b0;
        bm_addr   = clr_cnt;
        case (state)
            S_CLEAR: begin
                bm_we = 1'b1;
                if (clr_cnt == 12'(GRID_N - 1)) state_nxt = S_INIT;
            end
            S_INIT: begin
                bm_we   = 1'b1;
                bm_wd   = 1'b1;
                bm_addr = init_idx;
                if (init_k == 7'(INIT_LEN - 1)) state_nxt = S_IDLE;
            end
            S_IDLE:  if (iTick) state_nxt = S_CALC;
            S_CALC:  state_nxt = calc_wall ? S_DEAD : S_CHECK;
            S_CHECK: begin
                // Stepping onto the tail is legal only when the tail will move away this turn
                if (rd_bit && !(new_idx == fifo[rd_ptr] && !take_grow)) state_nxt = S_DEAD;
                else                                                     state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                bm_we     = 1'b1;
                bm_wd     = 1'b1;
                bm_addr   = new_idx;
                state_nxt = S_TRIM;
            end
            S_TRIM: begin
                bm_we     = !keep_tail && (tail_idx != new_idx);
                bm_addr   = tail_idx;
                state_nxt = S_IDLE;
            end
            S_DEAD:  if (iRestart) state_nxt = S_CLEAR;
            default: state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (bm_we && !iRST) bitmap[bm_addr] <= bm_wd;
    end

    always_ff @(posedge iCLK) begin
        if (!iRST && state == S_INIT)   fifo[wr_ptr] <= init_idx;
        if (!iRST && state == S_UPDATE) fifo[wr_ptr] <= new_idx;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oHit       <= 1'b0;
            oHead_X    <= 6'd0;
            oHead_Y    <= 6'd0;
            oLength    <= 7'd0;
            oMove_Done <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            clr_cnt    <= 12'd0;
            init_k     <= 7'd0;
            dir        <= 2'b01;
            grow_flag  <= 1'b0;
            keep_tail  <= 1'b0;
            rd_bit     <= 1'b0;
            tail_idx   <= 12'd0;
            new_idx    <= 12'd0;
            new_x      <= 6'd0;
            new_y      <= 6'd0;
        end else begin
            oHit       <= q_in ? bitmap[q_idx] : 1'b0;
            oMove_Done <= 1'b0;
            if (iGrow)                 grow_flag <= 1'b1;
            else if (state == S_TRIM)  grow_flag <= 1'b0;
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 12'd1;
                    init_k  <= 7'd0;
                end
                S_INIT: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                    init_k <= init_k + 7'd1;
                    if (init_k == 7'(INIT_LEN - 1)) begin
                        dir     <= 2'b01;
                        oHead_X <= 6'(START_X);
                        oHead_Y <= 6'(START_Y);
                        oLength <= 7'(INIT_LEN);
                    end
                end
                S_IDLE: if (iTick && iDir != (dir ^ 2'b11)) dir <= iDir;
                S_CALC: begin
                    new_x   <= calc_x;
                    new_y   <= calc_y;
                    new_idx <= calc_idx;
                    rd_bit  <= calc_wall ? 1'b0 : bitmap[calc_idx];
                end
                S_CHECK: begin
                    keep_tail <= take_grow;
                    tail_idx  <= fifo[rd_ptr];
                end
                S_UPDATE: begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    count   <= count + 1'b1;
                    oHead_X <= new_x;
                    oHead_Y <= new_y;
                end
                S_TRIM: begin
                    if (keep_tail) begin
                        oLength <= oLength + 7'd1;
                    end else begin
                        rd_ptr <= rd_ptr + 1'b1;
                        count  <= count - 1'b1;
                    end
                    oMove_Done <= 1'b1;
                end
                S_DEAD: if (iRestart) begin
                    clr_cnt <= 12'd0;
                    wr_ptr  <= '0;
                    rd_ptr  <= '0;
                    count   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_body_engine.sv
// tb/tb_snake_body_engine.sv - directed checks of snake_body_engine moves, growth, collisions and reset
module tb_snake_body_engine;
    logic       iCLK = 1'b0;
    logic       iRST, iTick, iGrow, iRestart;
    logic [1:0] iDir;
    logic [5:0] iQuery_X, iQuery_Y;
    logic       oHit, oBusy, oDead, oMove_Done;
    logic [5:0] oHead_X, oHead_Y;
    logic [6:0] oLength;

    int checks = 0;
    int errors = 0;
    int lat;

    snake_body_engine dut (
        .iCLK(iCLK), .iRST(iRST), .iTick(iTick), .iDir(iDir), .iGrow(iGrow),
        .iRestart(iRestart), .iQuery_X(iQuery_X), .iQuery_Y(iQuery_Y), .oHit(oHit),
        .oHead_X(oHead_X), .oHead_Y(oHead_Y), .oLength(oLength), .oBusy(oBusy),
        .oDead(oDead), .oMove_Done(oMove_Done)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (oBusy && n < 4000) begin
            cyc(1);
            n++;
        end
        chk(tag, oBusy, 0);
    endtask

    task automatic do_tick(input logic [1:0] d, output int l);
        iDir  = d;
        iTick = 1'b1;
        cyc(1);
        iTick = 1'b0;
        l = 1;
        while (!oMove_Done && !oDead && l < 10) begin
            cyc(1);
            l++;
        end
    endtask

    task automatic query(input int x, input int y, input int exp, input string tag);
        iQuery_X = 6'(x);
        iQuery_Y = 6'(y);
        cyc(1);
        chk(tag, oHit, exp);
    endtask

    task automatic head_is(input int x, input int y, input string tag);
        chk({tag, "_x"}, oHead_X, x);
        chk({tag, "_y"}, oHead_Y, y);
    endtask

    initial begin
        iRST = 1'b1; iTick = 1'b0; iGrow = 1'b0; iRestart = 1'b0;
        iDir = 2'b01; iQuery_X = 6'd0; iQuery_Y = 6'd0;
        cyc(2);
        chk("rst_busy", oBusy, 1);
        chk("rst_dead", oDead, 0);
        chk("rst_len", oLength, 0);
        chk("rst_done", oMove_Done, 0);
        chk("rst_hit", oHit, 0);
        head_is(0, 0, "rst_head");
        iRST = 1'b0;
        wait_idle("init_idle");
        chk("init_len", oLength, 4);
        head_is(32, 24, "init_head");
        for (int x = 29; x <= 32; x++) query(x, 24, 1, "init_body");
        query(33, 24, 0, "init_ahead");
        query(28, 24, 0, "init_behind");
        query(32, 50, 0, "off_grid");

        do_tick(2'b01, lat);
        chk("move_lat", lat, 5);
        head_is(33, 24, "move1");
        query(29, 24, 0, "move1_tail_gone");
        query(33, 24, 1, "move1_new_head");
        chk("move1_len", oLength, 4);

        iGrow = 1'b1; cyc(1); iGrow = 1'b0;
        do_tick(2'b11, lat);
        chk("grow_lat", lat, 5);
        head_is(33, 23, "grow");
        chk("grow_len", oLength, 5);
        query(30, 24, 1, "grow_tail_kept");

        do_tick(2'b10, lat);
        head_is(32, 23, "left");
        do_tick(2'b00, lat);
        chk("self_dead", oDead, 1);
        head_is(32, 23, "self_dead_head");
        chk("self_dead_len", oLength, 5);
        do_tick(2'b01, lat);
        cyc(6);
        chk("dead_no_move", oHead_X, 32);
        chk("dead_stays", oDead, 1);
        iRestart = 1'b1; cyc(1); iRestart = 1'b0;
        chk("restart_undead", oDead, 0);
        wait_idle("restart_idle");
        chk("restart_len", oLength, 4);
        head_is(32, 24, "restart_head");
        query(33, 23, 0, "restart_cleared");

        do_tick(2'b10, lat);
        chk("rev_lat", lat, 5);
        head_is(33, 24, "reverse_ignored");

        iDir = 2'b00; iTick = 1'b1; cyc(1); iTick = 1'b0; cyc(1);
        iRST = 1'b1; cyc(1);
        chk("midrst_len", oLength, 0);
        iRST = 1'b0;
        wait_idle("midrst_idle");
        chk("midrst_reinit_len", oLength, 4);
        head_is(32, 24, "midrst_head");
        query(33, 24, 0, "midrst_cleared");

        do_tick(2'b11, lat);
        do_tick(2'b10, lat);
        do_tick(2'b00, lat);
        chk("chase_lat", lat, 5);
        chk("chase_alive", oDead, 0);
        head_is(31, 24, "chase");
        query(31, 24, 1, "chase_head_bit");
        query(30, 24, 0, "chase_old_tail");
        chk("chase_len", oLength, 4);

        iRST = 1'b1; cyc(2); iRST = 1'b0;
        wait_idle("wall_idle");
        for (int i = 0; i < 31; i++) do_tick(2'b01, lat);
        head_is(63, 24, "edge");
        chk("edge_alive", oDead, 0);
        do_tick(2'b01, lat);
`ifdef SNAKE_WRAP_EN
        chk("wrap_alive", oDead, 0);
        head_is(0, 24, "wrap");
`else
        chk("wall_dead", oDead, 1);
        head_is(63, 24, "wall_head");
        iRestart = 1'b1; cyc(1); iRestart = 1'b0;
        wait_idle("wall_restart_idle");
        chk("wall_restart_len", oLength, 4);
        head_is(32, 24, "wall_restart");
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
